seq_timing_ctrl: RTL

//  Sequence counter and timing controller for the basic computer. Owns SC,
//  the start/stop flag S, the interrupt flip-flop R and the interrupt enable IEN.

---
 rtl/seq_timing_ctrl.sv | 101 ++++++++++
 1 files changed

// File: rtl/seq_timing_ctrl.sv
// Sequence counter and timing controller: owns SC, the run flag S, the
// interrupt-cycle flip-flop R and IEN, and drives the one-hot timing bus T.
module seq_timing_ctrl #(
  parameter int unsigned SC_W = 3,
  parameter int unsigned T_W  = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [7:0]      D,
  input  logic            I,
  input  logic [11:0]     ir_b,
  input  logic            fgi,
  input  logic            fgo,
  output logic [T_W-1:0]  T,
  output logic [SC_W-1:0] sc,
  output logic            R,
  output logic            ien,
  output logic            S,
  output logic            sc_clr,
  output logic            sc_ovf
);

  localparam logic [SC_W-1:0] SC_MAX = SC_W'(T_W - 1);

  logic [SC_W-1:0] sc_nxt;
  logic            s_nxt;
  logic            r_nxt;
  logic            ien_nxt;
  logic            ovf_nxt;
  logic            hlt;
  logic            ion;
  logic            iof;
  logic            int_end;
  logic            int_req;

  // T is already gated by S, so every term built from it is S-qualified.
  assign T = S ? (T_W'(1) << sc) : '0;

  assign sc_clr  = (R & T[2]) | ((D[0] | D[1] | D[2] | D[5]) & T[5]) |
                   ((D[3] | D[4]) & T[4]) | (D[6] & T[6]) | (D[7] & T[3]);
  assign hlt     = D[7] & ~I & T[3] & ir_b[0];
  assign ion     = D[7] &  I & T[3] & ir_b[7];
  assign iof     = D[7] &  I & T[3] & ir_b[6];
  assign int_end = R & T[2];
  assign int_req = S & ~T[0] & ~T[1] & ~T[2] & ien & (fgi | fgo);

  // Next-state for counter and control flags
  always_comb begin
    sc_nxt  = sc;
    s_nxt   = S;
    r_nxt   = R;
    ien_nxt = ien;
    ovf_nxt = sc_ovf;

    if (S) begin
      if (sc_clr) begin
        sc_nxt = '0;
      end else begin
        sc_nxt = sc + SC_W'(1);
        if (sc == SC_MAX) ovf_nxt = 1'b1;
      end
    end

    // HLT beats a simultaneous start; start is ignored while running
    if (hlt) begin
      s_nxt = 1'b0;
    end else if (!S && start) begin
      s_nxt = 1'b1;
    end

    if (int_end || iof) begin
      ien_nxt = 1'b0;
    end else if (ion) begin
      ien_nxt = 1'b1;
    end

    if (int_end) begin
      r_nxt = 1'b0;
    end else if (int_req) begin
      r_nxt = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sc     <= '0;
      S      <= 1'b0;
      R      <= 1'b0;
      ien    <= 1'b0;
      sc_ovf <= 1'b0;
    end else begin
      sc     <= sc_nxt;
      S      <= s_nxt;
      R      <= r_nxt;
      ien    <= ien_nxt;
      sc_ovf <= ovf_nxt;
    end
  end

endmodule
